vx_dram_arb: RTL and testbench
==============================

VX_DRAM_ARB -- requirements
Module: VX_dram_arb

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 2, number of cache DRAM ports merged (power of 2, ≥2).
REQ-002 SHALL have parameter DATA_WIDTH, default 512, DRAM line width in bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default 26, line-address width.
REQ-004 SHALL have parameter TAG_IN_WIDTH, default 8, per-input DRAM tag width.
REQ-005 SHALL derive LOG_NUM = log2(NUM_INPUTS) and TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_NUM.
REQ-006 SHALL have ports:
  clk  in  1  clock; all state on rising edge.
  reset  in  1  synchronous, active-low reset (0 = reset).
  in_req_valid  in  NUM_INPUTS  per-input request valid.
  in_req_rw  in  NUM_INPUTS  per-input write flag.
  in_req_byteen  in  NUM_INPUTS*DATA_WIDTH/8  per-input byte enables.
  in_req_addr  in  NUM_INPUTS*ADDR_WIDTH  per-input line address.
  in_req_data  in  NUM_INPUTS*DATA_WIDTH  per-input write data.
  in_req_tag  in  NUM_INPUTS*TAG_IN_WIDTH  per-input tag.
  in_req_ready  out  NUM_INPUTS  per-input accept.
  out_req_valid/rw/byteen/addr/data  out  1/1/DATA_WIDTH/8/ADDR_WIDTH/DATA_WIDTH  merged request.
  out_req_tag  out  TAG_OUT_WIDTH  merged tag.
  out_req_ready  in  1  DRAM accept.
  out_rsp_valid  in  1  DRAM response valid.
  out_rsp_data  in  DATA_WIDTH  response line.
  out_rsp_tag  in  TAG_OUT_WIDTH  response tag.
  out_rsp_ready  out  1  response accept.
  in_rsp_valid  out  NUM_INPUTS  per-input response valid.
  in_rsp_data  out  NUM_INPUTS*DATA_WIDTH  per-input response line.
  in_rsp_tag  out  NUM_INPUTS*TAG_IN_WIDTH  per-input response tag.
  in_rsp_ready  in  NUM_INPUTS  per-input response accept.

Function
REQ-007 SHALL pick one grant per cycle among asserted in_req_valid bits, round-robin, searching upward from priority pointer rr_ptr with wrap (NUM_INPUTS-1 -> 0).
REQ-008 SHALL hold request output in a one-entry register (out_valid_r plus payload); out_req_* driven only from the register.
REQ-009 SHALL define reg_free = !out_valid_r | out_req_ready; in_req_ready[i] = reg_free & grant[i]; at most one in_req_ready bit high per cycle.
REQ-010 On input handshake (in_req_valid[i] & in_req_ready[i]): register loads payload of input i, out_req_tag = {in_req_tag[i], i[LOG_NUM-1:0]} (index in LSBs), out_valid_r = 1, rr_ptr = (i+1) mod NUM_INPUTS.
REQ-011 On out_req_ready with out_valid_r and no new handshake: out_valid_r = 0.
REQ-012 Simultaneous drain and load: register replaced in the same cycle; sustained throughput 1 request/cycle; request latency 1 cycle input-to-output.
REQ-013 While out_valid_r & !out_req_ready: payload and tag stable; all in_req_ready = 0; rr_ptr unchanged.
REQ-014 No valid inputs: rr_ptr unchanged; grant = 0.
REQ-015 Response path combinational, zero latency: idx = out_rsp_tag[LOG_NUM-1:0]; in_rsp_valid[idx] = out_rsp_valid, others 0; in_rsp_tag[idx] = out_rsp_tag[TAG_OUT_WIDTH-1:LOG_NUM]; in_rsp_data of every input = out_rsp_data; out_rsp_ready = in_rsp_ready[idx].
REQ-016 Request and response paths SHALL be independent; simultaneous request and response handshakes both complete.
REQ-017 Payload SHALL be passed unmodified (rw, byteen, addr, data).

Reset
REQ-018 When reset = 0 at a clock edge: out_valid_r = 0, rr_ptr = 0; payload register may hold any value.
REQ-019 During reset and the cycle it is sampled: out_req_valid = 0, all in_req_ready = 0.
REQ-020 Reset mid-transfer: a pending un-accepted out request is discarded; no replay after reset release.
REQ-021 Response outputs SHALL remain combinational and need no reset state.

Verification
REQ-022 Single request: NUM_INPUTS=2, input 1 valid with addr 0x123, tag 0x5A, out_req_ready=1 -> next cycle out_req_valid=1, addr 0x123, out_req_tag=0xB5; rr_ptr=0.
REQ-023 Fairness: both inputs valid continuously, out_req_ready=1 -> grants alternate 0,1,0,1; throughput 1 request/cycle, no bubbles.
REQ-024 Backpressure: out_req_ready=0 for 5 cycles with register full -> in_req_ready=00 and out_req_* stable for 5 cycles; on release, next grant follows rr_ptr.
REQ-025 Response routing: out_rsp_valid=1, out_rsp_tag=0x0B5, in_rsp_ready=10 -> in_rsp_valid=10, in_rsp_tag[1]=0x5A, out_rsp_ready=1; with in_rsp_ready=01 -> out_rsp_ready=0.
REQ-026 Reset mid-operation: register full and stalled, reset=0 for one cycle -> out_req_valid=0 next cycle, rr_ptr=0; input 0 wins first after release when both inputs valid.

Source files
------------

// File: rtl/vx_dram_arb.sv
// vx_dram_arb
// Merges NUM_INPUTS cache DRAM request ports onto a single DRAM request port.
// Responses from DRAM are routed back to the requesting input.
//
// Request path:
//   Each cycle a round-robin arbiter picks one requesting input. The search
//   starts at rr_ptr and wraps from NUM_INPUTS-1 to 0. The winner's payload
//   is loaded into a one-entry output register. The input index is appended
//   in the LSBs of the outgoing tag. out_req_* come only from that register.
//   The register can be drained and reloaded in the same cycle, so the path
//   sustains one request per cycle with one cycle of latency.
// Response path:
//   Purely combinational. The tag LSBs select the destination input.
//
// Handshake rule (all ports): a transfer happens on a rising clk edge where
// valid and ready are both high. A valid source holds its payload stable
// until that edge.
//
// Ports:
//   clk, reset                   clock; synchronous active-low reset
//   in_req_*  / in_req_ready     per-input request channels (packed by input)
//   out_req_* / out_req_ready    merged DRAM request, tag = {in_tag, index}
//   out_rsp_* / out_rsp_ready    DRAM response
//   in_rsp_*  / in_rsp_ready     per-input response channels

module vx_dram_arb #(
   parameter int NUM_INPUTS   = 2,
   parameter int DATA_WIDTH   = 512,
   parameter int ADDR_WIDTH   = 26,
   parameter int TAG_IN_WIDTH = 8,
   localparam int LOG_NUM       = $clog2(NUM_INPUTS),
   localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_NUM,
   localparam int BE_WIDTH      = DATA_WIDTH / 8
) (
   input  logic                               clk,
   input  logic                               reset,

   input  logic [NUM_INPUTS-1:0]              in_req_valid,
   input  logic [NUM_INPUTS-1:0]              in_req_rw,
   input  logic [NUM_INPUTS*BE_WIDTH-1:0]     in_req_byteen,
   input  logic [NUM_INPUTS*ADDR_WIDTH-1:0]   in_req_addr,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0]   in_req_data,
   input  logic [NUM_INPUTS*TAG_IN_WIDTH-1:0] in_req_tag,
   output logic [NUM_INPUTS-1:0]              in_req_ready,

   output logic                               out_req_valid,
   output logic                               out_req_rw,
   output logic [BE_WIDTH-1:0]                out_req_byteen,
   output logic [ADDR_WIDTH-1:0]              out_req_addr,
   output logic [DATA_WIDTH-1:0]              out_req_data,
   output logic [TAG_OUT_WIDTH-1:0]           out_req_tag,
   input  logic                               out_req_ready,

   input  logic                               out_rsp_valid,
   input  logic [DATA_WIDTH-1:0]              out_rsp_data,
   input  logic [TAG_OUT_WIDTH-1:0]           out_rsp_tag,
   output logic                               out_rsp_ready,

   output logic [NUM_INPUTS-1:0]              in_rsp_valid,
   output logic [NUM_INPUTS*DATA_WIDTH-1:0]   in_rsp_data,
   output logic [NUM_INPUTS*TAG_IN_WIDTH-1:0] in_rsp_tag,
   input  logic [NUM_INPUTS-1:0]              in_rsp_ready
);

   // ---------------- request path ----------------
   logic                     out_valid_q, out_valid_d;
   logic [LOG_NUM-1:0]       rr_ptr_q, rr_ptr_d;
   logic                     rw_q, rw_d;
   logic [BE_WIDTH-1:0]      byteen_q, byteen_d;
   logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
   logic [DATA_WIDTH-1:0]    data_q, data_d;
   logic [TAG_OUT_WIDTH-1:0] tag_q, tag_d;

   logic [NUM_INPUTS-1:0]    grant;
   logic [LOG_NUM-1:0]       grant_idx;
   logic [LOG_NUM-1:0]       cand;
   logic                     found;
   logic                     reg_free;
   logic                     fire;

   // Round-robin search. NUM_INPUTS is a power of two, so the LOG_NUM-bit
   // addition wraps from NUM_INPUTS-1 back to 0 on its own.
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
         cand = rr_ptr_q + k[LOG_NUM-1:0];
         if (!found && in_req_valid[cand]) begin
            found     = 1'b1;
            grant_idx = cand;
         end
      end
      grant            = '0;
      grant[grant_idx] = found;
   end

   // While reset is low, every accept is forced low. This also covers the
   // cycle in which reset is sampled, so no request is taken then.
   assign reg_free     = !out_valid_q || out_req_ready;
   assign in_req_ready = grant & {NUM_INPUTS{reg_free && reset}};
   assign fire         = found && reg_free && reset;

   always_comb begin
      out_valid_d = out_valid_q;
      rr_ptr_d    = rr_ptr_q;
      rw_d        = rw_q;
      byteen_d    = byteen_q;
      addr_d      = addr_q;
      data_d      = data_q;
      tag_d       = tag_q;
      if (fire) begin
         // A load may replace an entry that is draining in this same cycle.
         out_valid_d = 1'b1;
         rr_ptr_d    = grant_idx + 1'b1;
         rw_d        = in_req_rw[grant_idx];
         byteen_d    = in_req_byteen[int'(grant_idx)*BE_WIDTH +: BE_WIDTH];
         addr_d      = in_req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
         data_d      = in_req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
         tag_d       = {in_req_tag[int'(grant_idx)*TAG_IN_WIDTH +: TAG_IN_WIDTH], grant_idx};
      end else if (out_req_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // A pending entry is dropped on reset; the payload needs no reset value.
   always_ff @(posedge clk) begin
      if (!reset) begin
         out_valid_q <= 1'b0;
         rr_ptr_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      rw_q     <= rw_d;
      byteen_q <= byteen_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      tag_q    <= tag_d;
   end

   assign out_req_valid  = out_valid_q && reset;
   assign out_req_rw     = rw_q;
   assign out_req_byteen = byteen_q;
   assign out_req_addr   = addr_q;
   assign out_req_data   = data_q;
   assign out_req_tag    = tag_q;

   // ---------------- response path ----------------
   logic [LOG_NUM-1:0] rsp_idx;

   assign rsp_idx = out_rsp_tag[LOG_NUM-1:0];

   always_comb begin
      in_rsp_valid          = '0;
      in_rsp_valid[rsp_idx] = out_rsp_valid;
   end

   // Data and tag go to every input; only the selected input sees valid.
   assign in_rsp_data   = {NUM_INPUTS{out_rsp_data}};
   assign in_rsp_tag    = {NUM_INPUTS{out_rsp_tag[TAG_OUT_WIDTH-1:LOG_NUM]}};
   assign out_rsp_ready = in_rsp_ready[rsp_idx];

endmodule

// File: tb/tb_vx_dram_arb.sv
`timescale 1ns/1ps
module tb_vx_dram_arb;

   localparam int N     = 2;
   localparam int DW    = 32;
   localparam int AW    = 26;
   localparam int TW    = 8;
   localparam int LN    = 1;
   localparam int TOW   = TW + LN;
   localparam int BW    = DW / 8;
   localparam int EXP_W = TOW + AW + DW + BW + 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]    in_req_valid, in_req_rw, in_req_ready;
   logic [N*BW-1:0] in_req_byteen;
   logic [N*AW-1:0] in_req_addr;
   logic [N*DW-1:0] in_req_data;
   logic [N*TW-1:0] in_req_tag;
   logic            out_req_valid, out_req_rw, out_req_ready;
   logic [BW-1:0]   out_req_byteen;
   logic [AW-1:0]   out_req_addr;
   logic [DW-1:0]   out_req_data;
   logic [TOW-1:0]  out_req_tag;
   logic            out_rsp_valid, out_rsp_ready;
   logic [DW-1:0]   out_rsp_data;
   logic [TOW-1:0]  out_rsp_tag;
   logic [N-1:0]    in_rsp_valid, in_rsp_ready;
   logic [N*DW-1:0] in_rsp_data;
   logic [N*TW-1:0] in_rsp_tag;

   vx_dram_arb #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TW)) dut (
      .clk(clk), .reset(reset),
      .in_req_valid(in_req_valid), .in_req_rw(in_req_rw), .in_req_byteen(in_req_byteen),
      .in_req_addr(in_req_addr), .in_req_data(in_req_data), .in_req_tag(in_req_tag),
      .in_req_ready(in_req_ready),
      .out_req_valid(out_req_valid), .out_req_rw(out_req_rw), .out_req_byteen(out_req_byteen),
      .out_req_addr(out_req_addr), .out_req_data(out_req_data), .out_req_tag(out_req_tag),
      .out_req_ready(out_req_ready),
      .out_rsp_valid(out_rsp_valid), .out_rsp_data(out_rsp_data), .out_rsp_tag(out_rsp_tag),
      .out_rsp_ready(out_rsp_ready),
      .in_rsp_valid(in_rsp_valid), .in_rsp_data(in_rsp_data), .in_rsp_tag(in_rsp_tag),
      .in_rsp_ready(in_rsp_ready)
   );

   int tests_run = 0;
   int tests_failed = 0;

   // ---------------- reference model ----------------
   // One pending outgoing request plus "which input has top priority next".
   logic           m_valid = 1'b0;
   logic           m_rw;
   logic [BW-1:0]  m_be;
   logic [AW-1:0]  m_addr;
   logic [DW-1:0]  m_data;
   logic [TOW-1:0] m_tag;
   int             m_ptr = 0;
   logic [EXP_W-1:0] exp_q[$];

   // Requester closest (cyclically upward) to the priority input, or -1.
   function automatic int winner();
      int best = -1;
      int bd = N;
      for (int i = 0; i < N; i++) begin
         if (in_req_valid[i]) begin
            int d = (i - m_ptr + N) % N;
            if (d < bd) begin
               bd = d;
               best = i;
            end
         end
      end
      return best;
   endfunction

   function automatic logic [N-1:0] exp_ready();
      logic [N-1:0] r = '0;
      int w = winner();
      if (reset && w >= 0 && (!m_valid || out_req_ready)) r[w] = 1'b1;
      return r;
   endfunction

   // Advance one clock and update the model from the inputs seen at the edge.
   task automatic tick();
      int w;
      w = winner();
      @(posedge clk);
      if (!reset) begin
         m_valid = 1'b0;
         m_ptr = 0;
         exp_q.delete();
      end else if (w >= 0 && (!m_valid || out_req_ready)) begin
         m_valid = 1'b1;
         m_rw    = in_req_rw[w];
         m_be    = in_req_byteen[w*BW +: BW];
         m_addr  = in_req_addr[w*AW +: AW];
         m_data  = in_req_data[w*DW +: DW];
         m_tag   = {in_req_tag[w*TW +: TW], w[LN-1:0]};
         m_ptr   = (w + 1) % N;
         exp_q.push_back({m_tag, m_addr, m_data, m_be, m_rw});
      end else if (out_req_ready) begin
         m_valid = 1'b0;
      end
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_req(input int i, input logic v, input logic [AW-1:0] a, input logic [TW-1:0] t);
      in_req_valid[i]        = v;
      in_req_rw[i]           = 1'($urandom_range(0, 1));
      in_req_byteen[i*BW +: BW] = BW'($urandom);
      in_req_addr[i*AW +: AW]   = a;
      in_req_data[i*DW +: DW]   = $urandom;
      in_req_tag[i*TW +: TW]    = t;
   endtask

   task automatic clear_inputs();
      in_req_valid = '0; in_req_rw = '0; in_req_byteen = '0;
      in_req_addr = '0; in_req_data = '0; in_req_tag = '0;
      out_rsp_valid = 1'b0; out_rsp_data = '0; out_rsp_tag = '0; in_rsp_ready = '0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      clear_inputs();
      out_req_ready = 1'b0;
      reset = 1'b0;
      drive_req(0, 1'b1, 26'h1, 8'h11);
      drive_req(1, 1'b1, 26'h2, 8'h22);
      #3;
      for (int c = 0; c < 3; c++) begin
         tests_run++;
         if (out_req_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_out_valid: got %b exp 0", out_req_valid);
         end
         tests_run++;
         if (in_req_ready !== 2'b00) begin
            tests_failed++; $display("FAIL reset_in_ready: got %b exp 00", in_req_ready);
         end
         tick();
         #3;
      end
      reset = 1'b1;
      clear_inputs();
      tick();
      tests_run++;
      if (out_req_valid !== 1'b0) begin
         tests_failed++; $display("FAIL reset_release_valid: got %b exp 0", out_req_valid);
      end
   endtask

   task automatic test_single();
      clear_inputs();
      out_req_ready = 1'b1;
      drive_req(1, 1'b1, 26'h123, 8'h5A);
      #4;
      tests_run++;
      if (in_req_ready !== 2'b10) begin
         tests_failed++; $display("FAIL single_ready: got %b exp 10", in_req_ready);
      end
      tick();
      in_req_valid = '0;
      #4;
      tests_run++;
      if (out_req_valid !== 1'b1) begin
         tests_failed++; $display("FAIL single_valid: got %b exp 1", out_req_valid);
      end
      tests_run++;
      if (out_req_addr !== 26'h123) begin
         tests_failed++; $display("FAIL single_addr: got %h exp 123", out_req_addr);
      end
      tests_run++;
      if (out_req_tag !== 9'h0B5) begin
         tests_failed++; $display("FAIL single_tag: got %h exp 0b5", out_req_tag);
      end
      tick();
      // Priority has wrapped back to input 0.
      drive_req(0, 1'b1, 26'h7, 8'h01);
      drive_req(1, 1'b1, 26'h8, 8'h02);
      #4;
      tests_run++;
      if (in_req_ready !== 2'b01) begin
         tests_failed++; $display("FAIL single_rr_ptr: got %b exp 01", in_req_ready);
      end
      tick();
      clear_inputs();
      tick();
   endtask

   task automatic test_fairness();
      int start;
      logic [N-1:0] e;
      clear_inputs();
      out_req_ready = 1'b1;
      start = m_ptr;
      for (int k = 0; k < 8; k++) begin
         drive_req(0, 1'b1, AW'($urandom), TW'($urandom));
         drive_req(1, 1'b1, AW'($urandom), TW'($urandom));
         #4;
         e = '0;
         e[(start + k) % N] = 1'b1;
         tests_run++;
         if (in_req_ready !== e) begin
            tests_failed++; $display("FAIL fair_grant k=%0d: got %b exp %b", k, in_req_ready, e);
         end
         if (k > 0) begin
            tests_run++;
            if (out_req_valid !== 1'b1 || out_req_tag[0] !== 1'((start + k - 1) % N)) begin
               tests_failed++;
               $display("FAIL fair_out k=%0d: got valid=%b idx=%b exp valid=1 idx=%0d",
                        k, out_req_valid, out_req_tag[0], (start + k - 1) % N);
            end
         end
         tick();
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_backpressure();
      logic [AW-1:0]  s_addr;
      logic [TOW-1:0] s_tag;
      logic [DW-1:0]  s_data;
      logic [N-1:0]   e;
      clear_inputs();
      out_req_ready = 1'b1;
      drive_req(0, 1'b1, 26'h3AA, 8'hC3);
      drive_req(1, 1'b1, 26'h155, 8'h3C);
      tick();
      out_req_ready = 1'b0;
      s_addr = m_addr; s_tag = m_tag; s_data = m_data;
      for (int c = 0; c < 5; c++) begin
         drive_req(0, 1'b1, AW'($urandom), TW'($urandom));
         drive_req(1, 1'b1, AW'($urandom), TW'($urandom));
         #4;
         tests_run++;
         if (in_req_ready !== 2'b00) begin
            tests_failed++; $display("FAIL bp_ready c=%0d: got %b exp 00", c, in_req_ready);
         end
         tests_run++;
         if (out_req_valid !== 1'b1 || out_req_addr !== s_addr || out_req_tag !== s_tag ||
             out_req_data !== s_data) begin
            tests_failed++;
            $display("FAIL bp_stable c=%0d: got v=%b a=%h t=%h d=%h exp v=1 a=%h t=%h d=%h", c,
                     out_req_valid, out_req_addr, out_req_tag, out_req_data, s_addr, s_tag, s_data);
         end
         tick();
      end
      out_req_ready = 1'b1;
      #4;
      e = '0;
      e[m_ptr] = 1'b1;
      tests_run++;
      if (in_req_ready !== e) begin
         tests_failed++; $display("FAIL bp_release: got %b exp %b", in_req_ready, e);
      end
      tick();
      clear_inputs();
      tick();
   endtask

   task automatic test_response();
      logic [DW-1:0] d;
      clear_inputs();
      d = $urandom;
      out_rsp_valid = 1'b1; out_rsp_tag = 9'h0B5; out_rsp_data = d; in_rsp_ready = 2'b10;
      #1;
      tests_run++;
      if (in_rsp_valid !== 2'b10) begin
         tests_failed++; $display("FAIL rsp_valid1: got %b exp 10", in_rsp_valid);
      end
      tests_run++;
      if (in_rsp_tag[15:8] !== 8'h5A) begin
         tests_failed++; $display("FAIL rsp_tag1: got %h exp 5a", in_rsp_tag[15:8]);
      end
      tests_run++;
      if (out_rsp_ready !== 1'b1) begin
         tests_failed++; $display("FAIL rsp_ready1: got %b exp 1", out_rsp_ready);
      end
      tests_run++;
      if (in_rsp_data !== {d, d}) begin
         tests_failed++; $display("FAIL rsp_data: got %h exp %h", in_rsp_data, {d, d});
      end
      in_rsp_ready = 2'b01;
      #1;
      tests_run++;
      if (out_rsp_ready !== 1'b0) begin
         tests_failed++; $display("FAIL rsp_ready_wrong: got %b exp 0", out_rsp_ready);
      end
      out_rsp_tag = 9'h0B4;
      #1;
      tests_run++;
      if (in_rsp_valid !== 2'b01 || in_rsp_tag[7:0] !== 8'h5A || out_rsp_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL rsp_route0: got v=%b t=%h r=%b exp v=01 t=5a r=1",
                  in_rsp_valid, in_rsp_tag[7:0], out_rsp_ready);
      end
      out_rsp_valid = 1'b0;
      #1;
      tests_run++;
      if (in_rsp_valid !== 2'b00) begin
         tests_failed++; $display("FAIL rsp_idle: got %b exp 00", in_rsp_valid);
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_reset_mid();
      clear_inputs();
      out_req_ready = 1'b1;
      drive_req(1, 1'b1, 26'h44, 8'h99);
      tick();
      out_req_ready = 1'b0;
      tick();
      reset = 1'b0;
      #4;
      tests_run++;
      if (out_req_valid !== 1'b0 || in_req_ready !== 2'b00) begin
         tests_failed++;
         $display("FAIL rmid_during: got v=%b r=%b exp v=0 r=00", out_req_valid, in_req_ready);
      end
      tick();
      reset = 1'b1;
      clear_inputs();
      #4;
      tests_run++;
      if (out_req_valid !== 1'b0) begin
         tests_failed++; $display("FAIL rmid_no_replay: got %b exp 0", out_req_valid);
      end
      out_req_ready = 1'b1;
      drive_req(0, 1'b1, 26'h10, 8'h01);
      drive_req(1, 1'b1, 26'h20, 8'h02);
      #1;
      tests_run++;
      if (in_req_ready !== 2'b01) begin
         tests_failed++; $display("FAIL rmid_first_grant: got %b exp 01", in_req_ready);
      end
      tick();
      clear_inputs();
      #4;
      tests_run++;
      if (out_req_valid !== 1'b1 || out_req_tag !== 9'h002 || out_req_addr !== 26'h10) begin
         tests_failed++;
         $display("FAIL rmid_out: got v=%b t=%h a=%h exp v=1 t=002 a=010",
                  out_req_valid, out_req_tag, out_req_addr);
      end
      tick();
   endtask

   task automatic test_random();
      logic [EXP_W-1:0] got, exp;
      logic [N-1:0]     ev;
      int               idx;
      exp_q.delete();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++)
            drive_req(i, 1'($urandom_range(0, 1)), AW'($urandom), TW'($urandom));
         out_req_ready = ($urandom_range(0, 3) != 0);
         reset         = ($urandom_range(0, 49) != 0);
         out_rsp_valid = 1'($urandom_range(0, 1));
         out_rsp_data  = $urandom;
         out_rsp_tag   = TOW'($urandom);
         in_rsp_ready  = N'($urandom);
         #4;
         tests_run++;
         if (in_req_ready !== exp_ready()) begin
            tests_failed++; $display("FAIL rnd_ready c=%0d: got %b exp %b", c, in_req_ready, exp_ready());
         end
         tests_run++;
         if (out_req_valid !== (m_valid && reset)) begin
            tests_failed++; $display("FAIL rnd_valid c=%0d: got %b exp %b", c, out_req_valid, m_valid && reset);
         end
         got = {out_req_tag, out_req_addr, out_req_data, out_req_byteen, out_req_rw};
         if (m_valid) begin
            exp = {m_tag, m_addr, m_data, m_be, m_rw};
            tests_run++;
            if (got !== exp) begin
               tests_failed++; $display("FAIL rnd_payload c=%0d: got %h exp %h", c, got, exp);
            end
         end
         if (out_req_valid && out_req_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++; $display("FAIL rnd_scoreboard c=%0d: got %h exp none", c, got);
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp) begin
                  tests_failed++; $display("FAIL rnd_scoreboard c=%0d: got %h exp %h", c, got, exp);
               end
            end
         end
         idx = int'(out_rsp_tag[LN-1:0]);
         ev = '0;
         ev[idx] = out_rsp_valid;
         tests_run++;
         if (in_rsp_valid !== ev || out_rsp_ready !== in_rsp_ready[idx] ||
             in_rsp_tag[idx*TW +: TW] !== out_rsp_tag[TOW-1:LN] ||
             in_rsp_data !== {N{out_rsp_data}}) begin
            tests_failed++;
            $display("FAIL rnd_rsp c=%0d: got v=%b r=%b t=%h exp v=%b r=%b t=%h", c, in_rsp_valid,
                     out_rsp_ready, in_rsp_tag[idx*TW +: TW], ev, in_rsp_ready[idx], out_rsp_tag[TOW-1:LN]);
         end
         tick();
      end
      reset = 1'b1;
      clear_inputs();
      tick();
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      clear_inputs();
      out_req_ready = 1'b0;
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_response();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
